if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch engine between the PC register and the IF/ID boundary. Takes the current PC, issues one SRAM-like read to instruction memory, tracks the outstanding transaction, and presents the fetched word with its PC to decode. It stalls the PC register while a fetch is in flight. On a flush, it discards any in-flight response and drops any buffered instruction.

## Interface
- No parameters; widths are fixed at 32 bits.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- pc_i  in  32  PC to fetch, from the PC register output.
- ce_i  in  1  fetch enable, from the PC register.
- flush_i  in  1  pipeline flush (exception/branch redirect).
- stall_i  in  1  downstream (decode) stall; the output register must hold.
- inst_req_o  out  1  memory request.
- inst_addr_o  out  32  request address.
- inst_addr_ok_i  in  1  request accepted by memory.
- inst_data_ok_i  in  1  read data valid.
- inst_rdata_i  in  32  read data.
- stall_req_o  out  1  asks the pipeline controller to stall the PC register.
- inst_o  out  32  fetched instruction.
- inst_pc_o  out  32  PC of inst_o.
- inst_valid_o  out  1  inst_o/inst_pc_o are meaningful.
- excp_adel_o  out  1  fetch address misaligned (pc[1:0]≠0); inst_o=0.

## Operation
- Only one transaction is outstanding at a time; addr_q and drop_q are internal registers.
- FSM states: IDLE, REQ, WAIT, HOLD.
- **IDLE**, ce_i=1, flush_i=0, stall_i=0:
  - Aligned pc_i: latch addr_q=pc_i and go to REQ.
  - Misaligned pc_i: load the output register with valid=1, excp_adel_o=1, inst_o=0, inst_pc_o=pc_i. No request is issued and the state stays IDLE.
- **REQ**: inst_req_o=1 and inst_addr_o=addr_q.
  - The request is never withdrawn.
  - inst_addr_ok_i=1 moves to WAIT.
- **WAIT**: on inst_data_ok_i=1:
  - drop_q=1: discard the data, clear drop_q, go to IDLE.
  - stall_i=0: load the output register (valid=1, inst_o=rdata, inst_pc_o=addr_q, excp=0) and go to IDLE.
  - stall_i=1: capture rdata into a skid buffer and go to HOLD.
- **HOLD**: when stall_i=0, move the skid buffer into the output register and go to IDLE.
- **flush_i=1**, any state:
  - Output register cleared: valid=0, excp=0.
  - REQ or WAIT: set drop_q; the FSM continues and drains the response.
  - HOLD: skid buffer discarded, go to IDLE.
  - IDLE: nothing is accepted that cycle.
- **stall_req_o** (combinational) = state∈{REQ,WAIT,HOLD} OR (IDLE AND ce_i AND aligned pc_i AND !flush_i AND !stall_i).
- **Output register with stall_i=1 and no flush**: it holds its value.
- **Output register with stall_i=0 and no new load**: valid drops to 0 (bubble).
- **ce_i=0 in IDLE**: no request, stall_req_o=0.

## Timing
- Reset:
  - state=IDLE, drop_q=0.
  - inst_req_o=0, inst_addr_o=0.
  - inst_o=0, inst_pc_o=0, inst_valid_o=0, excp_adel_o=0, stall_req_o=0.
- Minimum latency is 3 cycles: accept in cycle 0, REQ with addr_ok in cycle 1, data_ok in cycle 2, inst_valid_o=1 in cycle 3.
- inst_data_ok_i is ignored outside WAIT, which is the memory contract.
- Flush has priority over stall and over a data_ok in the same cycle; that data is dropped.
- Flush during REQ with addr_ok in the same cycle: go to WAIT with drop_q=1.
- Reset asserted mid-transaction: immediately IDLE. The memory side is reset by the same reset.

## Structure
- Shared package cpu_defs_pkg holds:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD}.
  - RESET_PC=32'hbfc00000.
  - INST_NOP=32'h0.
- One sub-module, if_skid_buffer: 1-entry data+pc holding register with load/clear/valid.

## Test plan
- **Back-to-back aligned fetch**: pc 0xbfc00000, addr_ok in the request cycle, data_ok next cycle with 0x24080001 → inst_valid_o=1, inst_o=0x24080001, inst_pc_o=0xbfc00000 in cycle 3; stall_req_o high in cycles 0–2.
- **Slow memory**: addr_ok delayed 3 cycles and data_ok delayed 2 → inst_req_o and inst_addr_o held stable throughout; output appears 1 cycle after data_ok.
- **Flush in WAIT**: flush_i while waiting; data_ok with 0xdeadbeef arrives later → inst_valid_o never 1 for it; next fetch from the new PC is delivered normally.
- **Decode stall at data arrival**: stall_i=1 on the data_ok cycle and held 4 cycles → previous output held; state HOLD; new instruction appears the cycle after stall_i falls.
- **Misaligned PC**: pc 0xbfc00002 → no inst_req_o; next cycle inst_valid_o=1, excp_adel_o=1, inst_pc_o=0xbfc00002.
- **Reset during REQ**: rst_i asserted asynchronously → all outputs 0 before the next edge; state IDLE.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared fetch-stage types and constants
package cpu_defs_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] INST_NOP = 32'h0;

    function automatic logic is_aligned(input logic [31:0] a);
        return a[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: SRAM-like instruction memory request/response bus
interface if_fetch_unit_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );

endinterface

// File: rtl/if_skid_buffer.sv
// if_skid_buffer: one-entry holding register for a response that arrives while decode stalls
module if_skid_buffer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] inst_d,
    input  logic [31:0] pc_d,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        valid
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inst  <= '0;
            pc    <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            inst  <= inst_d;
            pc    <= pc_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: single-outstanding instruction fetch between the PC register and IF/ID
module if_fetch_unit
    import cpu_defs_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     pc_i,
    input  logic            ce_i,
    input  logic            flush_i,
    input  logic            stall_i,
    if_fetch_unit_if.master mem,
    output logic            stall_req_o,
    output logic [31:0]     inst_o,
    output logic [31:0]     inst_pc_o,
    output logic            inst_valid_o,
    output logic            excp_adel_o
);

    fetch_state_t state;
    logic [31:0]  addr_q, sk_inst, sk_pc;
    logic         drop_q, sk_valid, sk_load, sk_clear, accept, deliver;

    assign mem.inst_req  = state == REQ;
    assign mem.inst_addr = addr_q;

    always_comb begin
        accept      = state == IDLE && ce_i && !flush_i && !stall_i;
        deliver     = state == WAIT && mem.inst_data_ok && !flush_i && !drop_q;
        sk_load     = deliver && stall_i;
        sk_clear    = state == HOLD && (flush_i || !stall_i);
        stall_req_o = !rst_i && (state != IDLE || (accept && is_aligned(pc_i)));
    end

    if_skid_buffer u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load   (sk_load),
        .clear  (sk_clear),
        .inst_d (mem.inst_rdata),
        .pc_d   (addr_q),
        .inst   (sk_inst),
        .pc     (sk_pc),
        .valid  (sk_valid)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            addr_q       <= '0;
            drop_q       <= 1'b0;
            inst_o       <= INST_NOP;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
            excp_adel_o  <= 1'b0;
        end else if (flush_i) begin
            inst_valid_o <= 1'b0;
            excp_adel_o  <= 1'b0;
            // an in-flight transaction must still drain; drop_q marks its data as dead
            case (state)
                REQ: begin
                    drop_q <= 1'b1;
                    if (mem.inst_addr_ok) state <= WAIT;
                end
                WAIT: begin
                    drop_q <= !mem.inst_data_ok;
                    if (mem.inst_data_ok) state <= IDLE;
                end
                HOLD: state <= IDLE;
                default: ;
            endcase
        end else begin
            if (!stall_i) begin
                inst_valid_o <= 1'b0;
                excp_adel_o  <= 1'b0;
            end
            case (state)
                IDLE: if (accept) begin
                    if (is_aligned(pc_i)) begin
                        addr_q <= pc_i;
                        state  <= REQ;
                    end else begin
                        inst_valid_o <= 1'b1;
                        excp_adel_o  <= 1'b1;
                        inst_o       <= INST_NOP;
                        inst_pc_o    <= pc_i;
                    end
                end
                REQ: if (mem.inst_addr_ok) state <= WAIT;
                WAIT: if (mem.inst_data_ok) begin
                    drop_q <= 1'b0;
                    state  <= (drop_q || !stall_i) ? IDLE : HOLD;
                    if (deliver && !stall_i) begin
                        inst_valid_o <= 1'b1;
                        inst_o       <= mem.inst_rdata;
                        inst_pc_o    <= addr_q;
                    end
                end
                HOLD: if (!stall_i) begin
                    state        <= IDLE;
                    inst_valid_o <= sk_valid;
                    inst_o       <= sk_inst;
                    inst_pc_o    <= sk_pc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for the instruction fetch unit
module tb_if_fetch_unit;
    import cpu_defs_pkg::*;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        excp;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, ce = 1'b0, flush = 1'b0, stall = 1'b0;
    logic [31:0] pc = '0;
    logic        stall_req, inst_valid, excp;
    logic [31:0] inst, inst_pc;
    logic        hold_edge = 1'b0;
    int          tests = 0, fails = 0;
    exp_t        exp_q[$];
    exp_t        got, want;

    if_fetch_unit_if mem();

    if_fetch_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pc_i         (pc),
        .ce_i         (ce),
        .flush_i      (flush),
        .stall_i      (stall),
        .mem          (mem),
        .stall_req_o  (stall_req),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc),
        .inst_valid_o (inst_valid),
        .excp_adel_o  (excp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // an output register update only happens on edges where decode was not stalled
    always @(posedge clk) hold_edge = stall;

    always @(negedge clk) begin
        if (!rst && inst_valid && !hold_edge) begin
            got = {inst, inst_pc, excp};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got inst=%h pc=%h excp=%b expected none", inst, inst_pc, excp);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    fails++;
                    $display("FAIL output: got inst=%h pc=%h excp=%b expected inst=%h pc=%h excp=%b",
                             got.inst, got.pc, got.excp, want.inst, want.pc, want.excp);
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int adly, input int ddly);
        ce = 1'b1;
        pc = a;
        @(negedge clk);
        checkb("accept_stall_req", stall_req, 1'b1);
        step();
        ce = 1'b0;
        repeat (adly) begin
            @(negedge clk);
            checkb("req_held", mem.inst_req, 1'b1);
            check("addr_held", mem.inst_addr, a);
            checkb("req_stall_req", stall_req, 1'b1);
            step();
        end
        mem.inst_addr_ok = 1'b1;
        @(negedge clk);
        checkb("req", mem.inst_req, 1'b1);
        check("addr", mem.inst_addr, a);
        step();
        mem.inst_addr_ok = 1'b0;
        repeat (ddly) begin
            @(negedge clk);
            checkb("wait_stall_req", stall_req, 1'b1);
            checkb("no_req_in_wait", mem.inst_req, 1'b0);
            step();
        end
        mem.inst_data_ok = 1'b1;
        mem.inst_rdata   = d;
        exp_q.push_back({d, a, 1'b0});
        @(negedge clk);
        checkb("data_stall_req", stall_req, 1'b1);
        step();
        mem.inst_data_ok = 1'b0;
        @(negedge clk);
        checkb("valid_latency", inst_valid, 1'b1);
        checkb("idle_stall_req", stall_req, 1'b0);
        step();
    endtask

    initial begin
        mem.inst_addr_ok = 1'b0;
        mem.inst_data_ok = 1'b0;
        mem.inst_rdata   = '0;
        repeat (2) @(negedge clk);
        checkb("rst_valid", inst_valid, 1'b0);
        checkb("rst_excp", excp, 1'b0);
        checkb("rst_stall_req", stall_req, 1'b0);
        checkb("rst_req", mem.inst_req, 1'b0);
        check("rst_addr", mem.inst_addr, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        step();
        rst = 1'b0;
        @(negedge clk);
        checkb("ce_off_req", mem.inst_req, 1'b0);
        checkb("ce_off_stall_req", stall_req, 1'b0);
        step();

        fetch(RESET_PC, 32'h24080001, 0, 0);
        fetch(32'hbfc00004, 32'h8d090004, 3, 2);

        // flush while waiting for data: the late response must vanish
        ce = 1'b1;
        pc = 32'hbfc00008;
        step();
        ce = 1'b0;
        mem.inst_addr_ok = 1'b1;
        step();
        mem.inst_addr_ok = 1'b0;
        @(negedge clk);
        check("pre_flush_state", 32'(dut.state), 32'(WAIT));
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        checkb("flush_drop", dut.drop_q, 1'b1);
        check("flush_still_wait", 32'(dut.state), 32'(WAIT));
        step();
        step();
        mem.inst_data_ok = 1'b1;
        mem.inst_rdata   = 32'hdeadbeef;
        step();
        mem.inst_data_ok = 1'b0;
        @(negedge clk);
        checkb("flushed_valid", inst_valid, 1'b0);
        checkb("drop_cleared", dut.drop_q, 1'b0);
        check("flushed_state", 32'(dut.state), 32'(IDLE));
        step();
        fetch(32'hbfc00100, 32'h3c1d0001, 0, 1);

        // decode stall on the data cycle, held four cycles
        ce = 1'b1;
        pc = 32'hbfc00200;
        step();
        ce = 1'b0;
        mem.inst_addr_ok = 1'b1;
        step();
        mem.inst_addr_ok = 1'b0;
        mem.inst_data_ok = 1'b1;
        mem.inst_rdata   = 32'h00851021;
        stall = 1'b1;
        exp_q.push_back({32'h00851021, 32'hbfc00200, 1'b0});
        step();
        mem.inst_data_ok = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hold_state", 32'(dut.state), 32'(HOLD));
            checkb("hold_valid", inst_valid, 1'b0);
            check("hold_pc", inst_pc, 32'hbfc00100);
            step();
        end
        stall = 1'b0;
        step();
        @(negedge clk);
        checkb("unstall_valid", inst_valid, 1'b1);
        check("unstall_state", 32'(dut.state), 32'(IDLE));
        step();

        // flush in HOLD discards the skid entry
        ce = 1'b1;
        pc = 32'hbfc00300;
        step();
        ce = 1'b0;
        mem.inst_addr_ok = 1'b1;
        step();
        mem.inst_addr_ok = 1'b0;
        mem.inst_data_ok = 1'b1;
        mem.inst_rdata   = 32'h11111111;
        stall = 1'b1;
        step();
        mem.inst_data_ok = 1'b0;
        @(negedge clk);
        check("skid_state", 32'(dut.state), 32'(HOLD));
        flush = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check("hold_flush_state", 32'(dut.state), 32'(IDLE));
        checkb("hold_flush_valid", inst_valid, 1'b0);
        step();
        @(negedge clk);
        checkb("skid_not_leaked", inst_valid, 1'b0);
        step();

        // misaligned PC
        ce = 1'b1;
        pc = 32'hbfc00002;
        @(negedge clk);
        checkb("adel_no_req", mem.inst_req, 1'b0);
        checkb("adel_stall_req", stall_req, 1'b0);
        exp_q.push_back({32'h0, 32'hbfc00002, 1'b1});
        step();
        ce = 1'b0;
        @(negedge clk);
        checkb("adel_valid", inst_valid, 1'b1);
        checkb("adel_excp", excp, 1'b1);
        check("adel_state", 32'(dut.state), 32'(IDLE));
        checkb("adel_no_req_after", mem.inst_req, 1'b0);
        step();

        // asynchronous reset in the middle of a request
        ce = 1'b1;
        pc = 32'hbfc00400;
        step();
        ce = 1'b0;
        @(negedge clk);
        checkb("pre_rst_req", mem.inst_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkb("arst_req", mem.inst_req, 1'b0);
        check("arst_addr", mem.inst_addr, 32'h0);
        checkb("arst_stall_req", stall_req, 1'b0);
        checkb("arst_valid", inst_valid, 1'b0);
        check("arst_inst_pc", inst_pc, 32'h0);
        check("arst_state", 32'(dut.state), 32'(IDLE));
        step();
        step();
        rst = 1'b0;
        step();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
